// File: rtl/clk_div_mon_pkg.sv
// Shared types for the divided-clock period/duty monitor.
package clk_div_mon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2,
        LOCKED    = 2'd3
    } mon_state_e;

    function automatic logic within_tol(input logic [31:0] value,
                                        input logic [31:0] target,
                                        input logic [31:0] tol);
        logic [31:0] diff;
        if (value >= target) begin
            diff = value - target;
        end else begin
            diff = target - value;
        end
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/clk_div_edge_det.sv
// Rising/falling edge detector for a signal already synchronous to i_clk.
module clk_div_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_d_q;

    // Previous-cycle copy of the monitored signal
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_d_q <= 1'b0;
        end else begin
            r_d_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_d_q;
    assign o_fall = ~i_sig & r_d_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high phase of a divided clock in source-clock cycles,
// declares lock after a run of matching periods and flags later deviations.
module clk_div_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int unsigned DIV_FACTOR = 10,
    parameter int unsigned TOL        = 0,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div_in,
    input  logic             en,
    input  logic             err_clr,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic [CNT_W-1:0] high_out,
    output logic             locked,
    output logic             err,
    output logic [15:0]      edge_cnt
);

    localparam logic [CNT_W-1:0] CYC_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LOCK_CNT  = CNT_W'(LOCK_COUNT);
    localparam logic [31:0]      STALL_LIM = 32'(2 * DIV_FACTOR);

    mon_state_e       r_state;
    mon_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_good;
    logic [CNT_W-1:0] w_good_nxt;
    logic [CNT_W-1:0] w_good_inc;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic [15:0]      r_edge_cnt;
    logic             r_locked;
    logic             w_locked_nxt;
    logic             r_err;
    logic             r_pv;
    logic             w_pv_nxt;
    logic             w_err_set;
    logic             w_rise;
    logic             w_fall;
    logic             w_good_per;
    logic             w_stall;
    logic             w_measuring;
    logic             w_clear;

    clk_div_edge_det u_edge_det (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_sig  (clk_div_in),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_good_per  = within_tol(32'(r_cyc), DIV_FACTOR, TOL);
    // A rise on the threshold edge is a (bad) period, not a stall
    assign w_stall     = ~w_rise & (32'(r_cyc) >= STALL_LIM);
    assign w_good_inc  = r_good + CNT_W'(1);
    assign w_measuring = en & ((r_state == MEASURE) | (r_state == LOCKED));
    assign w_clear     = ~en | (r_state == IDLE);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, lock bookkeeping and error-set decode
    always_comb begin
        w_state_nxt  = r_state;
        w_good_nxt   = r_good;
        w_locked_nxt = r_locked;
        w_pv_nxt     = 1'b0;
        w_err_set    = 1'b0;
        if (!en) begin
            w_state_nxt  = IDLE;
            w_good_nxt   = {CNT_W{1'b0}};
            w_locked_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt  = WAIT_EDGE;
                    w_good_nxt   = {CNT_W{1'b0}};
                    w_locked_nxt = 1'b0;
                end
                WAIT_EDGE: begin
                    if (w_rise) begin
                        w_state_nxt = MEASURE;
                    end else begin
                        w_state_nxt = WAIT_EDGE;
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        w_pv_nxt = 1'b1;
                        if (w_good_per) begin
                            w_good_nxt = w_good_inc;
                            if (w_good_inc >= LOCK_CNT) begin
                                w_state_nxt  = LOCKED;
                                w_locked_nxt = 1'b1;
                            end else begin
                                w_state_nxt = MEASURE;
                            end
                        end else begin
                            w_good_nxt = {CNT_W{1'b0}};
                        end
                    end else if (w_stall) begin
                        w_state_nxt = WAIT_EDGE;
                        w_good_nxt  = {CNT_W{1'b0}};
                    end else begin
                        w_state_nxt = MEASURE;
                    end
                end
                LOCKED: begin
                    if (w_rise) begin
                        w_pv_nxt = 1'b1;
                        if (!w_good_per) begin
                            w_state_nxt  = MEASURE;
                            w_good_nxt   = {CNT_W{1'b0}};
                            w_locked_nxt = 1'b0;
                            w_err_set    = 1'b1;
                        end else begin
                            w_state_nxt = LOCKED;
                        end
                    end else if (w_stall) begin
                        w_state_nxt  = WAIT_EDGE;
                        w_good_nxt   = {CNT_W{1'b0}};
                        w_locked_nxt = 1'b0;
                        w_err_set    = 1'b1;
                    end else begin
                        w_state_nxt = LOCKED;
                    end
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_good_nxt   = {CNT_W{1'b0}};
                    w_locked_nxt = 1'b0;
                end
            endcase
        end
    end

    // Counters, measurement captures and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc      <= {CNT_W{1'b0}};
            r_good     <= {CNT_W{1'b0}};
            r_period   <= {CNT_W{1'b0}};
            r_high     <= {CNT_W{1'b0}};
            r_edge_cnt <= 16'd0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_pv       <= 1'b0;
        end else begin
            r_good   <= w_good_nxt;
            r_locked <= w_locked_nxt;
            r_pv     <= w_pv_nxt;

            if (w_clear) begin
                r_cyc <= {CNT_W{1'b0}};
            end else if (w_rise) begin
                r_cyc <= CNT_W'(1);
            end else if (r_cyc != CYC_MAX) begin
                r_cyc <= r_cyc + CNT_W'(1);
            end else begin
                r_cyc <= r_cyc;
            end

            if (w_clear) begin
                r_edge_cnt <= 16'd0;
            end else if (w_rise) begin
                r_edge_cnt <= r_edge_cnt + 16'd1;
            end else begin
                r_edge_cnt <= r_edge_cnt;
            end

            if (w_pv_nxt) begin
                r_period <= r_cyc;
            end else begin
                r_period <= r_period;
            end

            if (w_fall && w_measuring) begin
                r_high <= r_cyc;
            end else begin
                r_high <= r_high;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign period_out   = r_period;
    assign period_valid = r_pv;
    assign high_out     = r_high;
    assign locked       = r_locked;
    assign err          = r_err;
    assign edge_cnt     = r_edge_cnt;

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Period/duty monitor placed directly downstream of `clock_divider`. It samples the divided clock `clk_out` in the source `clk` domain and measures every period and high phase in `clk` cycles. It declares lock once a run of periods matches `DIV_FACTOR`, and raises a sticky error on any later deviation or stall. It is the bench-and-silicon check that the divider produces the ratio it was built for.

## Interface
Parameters:
- `DIV_FACTOR`, 10: expected full period of the divided clock, in `clk` cycles.
- `TOL`, 0: allowed absolute deviation of a measured period from `DIV_FACTOR`.
- `LOCK_COUNT`, 4: consecutive in-tolerance periods required to assert `locked`.
- `CNT_W`, 16: width of the period, high-phase and cycle counters.

Ports:
- `clk` in 1: system clock, the same clock that drives `clock_divider`.
- `rst` in 1: reset, asynchronous and active-high.
- `clk_div_in` in 1: divided clock (`clk_out` of `clock_divider`); it is synchronous to `clk`, so no synchronizer is used.
- `en` in 1: monitor enable.
- `err_clr` in 1: single-cycle clear of `err`.
- `period_out` out `CNT_W`: last measured period.
- `period_valid` out 1: one-cycle pulse when `period_out` updates.
- `high_out` out `CNT_W`: last measured high-phase length.
- `locked` out 1: the ratio is confirmed.
- `err` out 1: sticky mismatch or stall flag.
- `edge_cnt` out 16: count of rising edges seen while enabled; wraps.

## Operation
Edge detection:
- One register `d_q` holds `clk_div_in`.
- `rise = clk_div_in & ~d_q`.
- `fall = ~clk_div_in & d_q`.

Cycle counter `cyc`:
- Loads 1 on `rise`, otherwise increments.
- Saturates at 2^CNT_W-1.

Measurement:
- On `rise` in MEASURE or LOCKED: `period_out <= cyc` and `period_valid` pulses.
- On `fall`: `high_out <= cyc`.
- A period is good iff |`cyc` − `DIV_FACTOR`| ≤ `TOL`.
- Stall: `cyc` ≥ 2·`DIV_FACTOR` with no `rise`.

State machine:
- IDLE: entered on reset or `en`=0. Clears `cyc`, the good-period count, `locked` and `edge_cnt`. `err` is held. Goes to WAIT_EDGE when `en`=1.
- WAIT_EDGE: the first `rise` is discarded as a partial period; it loads `cyc` and moves to MEASURE.
- MEASURE, on `rise`:
  - A good period increments the good count.
  - When the count reaches `LOCK_COUNT`, go to LOCKED and set `locked`.
  - A bad period clears the good count and stays in MEASURE.
  - A stall goes to WAIT_EDGE.
- LOCKED:
  - Good period: no change.
  - Bad period: set `err`, clear `locked`, clear the good count, go to MEASURE.
  - Stall: set `err`, clear `locked`, go to WAIT_EDGE.
- `en` falling in any state returns to IDLE on the next edge.

Flags and counters:
- `err` is cleared by `err_clr`; a new error set in the same cycle wins.
- `edge_cnt` increments on every `rise` while not in IDLE.

## Timing
- All outputs are registered.
- Reset value of every output is 0; on `rst` assertion all outputs drop to 0 immediately and the FSM enters IDLE.
- If `clk_div_in` changes after `clk` edge E, `rise`/`fall` is taken at edge E+1. `period_out`, `high_out`, `period_valid`, `edge_cnt`, `locked` and `err` are valid in the cycle after E+1 (latency 1 clock).
- `period_valid` is high for exactly one cycle per measured rise; it never fires on the discarded WAIT_EDGE rise.
- Stall is detected on the edge where `cyc` reaches 2·`DIV_FACTOR`.
- A rise on that same edge takes precedence over the stall.
- Reset mid-lock: after release the first rise is again discarded, and relock needs `LOCK_COUNT` fresh good periods.

## Structure
- Package `clk_div_mon_pkg`: FSM state enum (IDLE, WAIT_EDGE, MEASURE, LOCKED).
- Sub-module `clk_div_edge_det`: the `d_q` register plus `rise`/`fall` outputs.
- Top level holds the counters, comparator and FSM.

## Test plan
All scenarios pair the monitor with `clock_divider #(.DIV_FACTOR(10))` and use monitor `DIV_FACTOR`=10, `TOL`=0, `LOCK_COUNT`=4.
- Reset 10 ns, then `en`=1 → first rise discarded; `period_out`=10 with `period_valid` every 10 cycles; `locked`=1 after the 5th rise; `err`=0.
- Same run → `high_out`=5 after every fall; `edge_cnt` increments by 1 per rise.
- Locked, then hold `clk_div_in` low → on the 20th cycle after the last rise, `err`=1 and `locked`=0; the FSM is in WAIT_EDGE.
- Locked, then inject one 11-cycle period → `period_out`=11, `err`=1, `locked`=0; `locked`=1 again after 4 good 10-cycle periods.
- `err_clr` asserted on the same edge as a new bad period → `err` stays 1; `err_clr` alone later → `err`=0.
- Async `rst` pulse while locked → all outputs 0 without waiting for a clock edge; after release the first rise is discarded and relock takes 5 rises.
